// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage, the hazard/execute logic and the
// instruction memory port.
interface fetch_stage_if;
  logic        stallF_i;
  logic        stallD_i;
  logic        flushD_i;
  logic        pcsrcE_i;
  logic [31:0] pctargetE_i;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;

  logic [31:0] instrD_o;
  logic [31:0] pcD_o;
  logic [31:0] pcplus4D_o;
  logic        validD_o;

  // Fetch stage side.
  modport master (
    input  stallF_i, stallD_i, flushD_i, pcsrcE_i, pctargetE_i,
    input  imem_ack_i, imem_rdata_i,
    output imem_req_o, imem_addr_o,
    output instrD_o, pcD_o, pcplus4D_o, validD_o
  );

  // Environment side: hazard unit, execute stage and instruction memory.
  modport slave (
    output stallF_i, stallD_i, flushD_i, pcsrcE_i, pctargetE_i,
    output imem_ack_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o,
    input  instrD_o, pcD_o, pcplus4D_o, validD_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a req/ack memory port, one-entry hold buffer,
// redirect draining and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;
  typedef enum logic [1:0] {OFFER_NONE, OFFER_BUBBLE, OFFER_INSTR} offer_t;

  state_t      state;
  logic [31:0] pcF;
  logic [31:0] holdBuf;
  logic [31:0] pendingPc;
  logic        reqQ;

  logic [31:0] instrQ;
  logic [31:0] pcQ;
  logic [31:0] pcPlus4Q;
  logic        validQ;

  logic [31:0] pcPlus4F;
  logic [31:0] targetPc;
  offer_t      offer;
  logic [31:0] offerInstr;

  assign pcPlus4F = pcF + 32'd4;
  assign targetPc = {bus.pctargetE_i[31:2], 2'b00};

  // What the fetch side presents to IF/ID this cycle, before flush/stall.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    offer      = OFFER_NONE;
    offerInstr = bus.imem_rdata_i;
    unique case (state)
      IDLE: offer = OFFER_NONE;
      FETCH: begin
        if (bus.imem_ack_i && !bus.pcsrcE_i && !bus.stallF_i) offer = OFFER_INSTR;
        else                                                   offer = OFFER_BUBBLE;
      end
      HOLD: begin
        offerInstr = holdBuf;
        if (bus.pcsrcE_i)      offer = OFFER_BUBBLE;
        else if (bus.stallF_i) offer = OFFER_NONE;
        else                   offer = OFFER_INSTR;
      end
      DRAIN: offer = OFFER_BUBBLE;
      default: offer = OFFER_BUBBLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      pcF       <= RESET_PC;
      holdBuf   <= '0;
      pendingPc <= '0;
      reqQ      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= FETCH;
          reqQ  <= 1'b1;
        end
        FETCH: begin
          if (bus.imem_ack_i) begin
            if (bus.pcsrcE_i) begin
              pcF <= targetPc;
            end else if (bus.stallF_i) begin
              holdBuf <= bus.imem_rdata_i;
              state   <= HOLD;
              reqQ    <= 1'b0;
            end else begin
              pcF <= pcPlus4F;
            end
          end else if (bus.pcsrcE_i) begin
            // The memory still owes us a response; remember where to go after it.
            pendingPc <= targetPc;
            state     <= DRAIN;
          end
        end
        HOLD: begin
          if (bus.pcsrcE_i) begin
            pcF   <= targetPc;
            state <= FETCH;
            reqQ  <= 1'b1;
          end else if (!bus.stallF_i) begin
            pcF   <= pcPlus4F;
            state <= FETCH;
            reqQ  <= 1'b1;
          end
        end
        DRAIN: begin
          if (bus.pcsrcE_i) pendingPc <= targetPc;
          if (bus.imem_ack_i) begin
            pcF   <= bus.pcsrcE_i ? targetPc : pendingPc;
            state <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
          reqQ  <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register: flush beats stall, stall beats whatever fetch offers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instrQ   <= NOP_INSTR;
      pcQ      <= '0;
      pcPlus4Q <= '0;
      validQ   <= 1'b0;
    end else if (bus.flushD_i) begin
      instrQ   <= NOP_INSTR;
      pcQ      <= '0;
      pcPlus4Q <= '0;
      validQ   <= 1'b0;
    end else if (!bus.stallD_i) begin
      unique case (offer)
        OFFER_BUBBLE: begin
          instrQ   <= NOP_INSTR;
          pcQ      <= '0;
          pcPlus4Q <= '0;
          validQ   <= 1'b0;
        end
        OFFER_INSTR: begin
          instrQ   <= offerInstr;
          pcQ      <= pcF;
          pcPlus4Q <= pcPlus4F;
          validQ   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_req_o  = reqQ;
  assign bus.imem_addr_o = pcF;
  assign bus.instrD_o    = instrQ;
  assign bus.pcD_o       = pcQ;
  assign bus.pcplus4D_o  = pcPlus4Q;
  assign bus.validD_o    = validQ;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with fixed expected
// values, then randomized traffic checked against a flag-based reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  int   nCompared   = 0;
  int   nMismatched = 0;

  always #5 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  // Reference model: a request is in flight once started unless a word is parked.
  logic [31:0] mPc, mBuf, mPend, mInstr, mPcD, mPc4D;
  logic        mValid;
  bit          mStarted, mHeld, mDraining;

  function automatic void model_reset();
    mPc = 32'h0; mBuf = 32'h0; mPend = 32'h0;
    mInstr = NOP; mPcD = 32'h0; mPc4D = 32'h0; mValid = 1'b0;
    mStarted = 0; mHeld = 0; mDraining = 0;
  endfunction

  function automatic void model_step();
    int          kind = 0;  // 0 keep, 1 bubble, 2 instruction
    logic [31:0] word = 32'h0;
    logic [31:0] atPc = mPc;
    logic [31:0] tgt  = bus.pctargetE_i & 32'hFFFF_FFFC;
    if (!mStarted) begin
      mStarted = 1;
    end else if (mHeld) begin
      if (bus.pcsrcE_i) begin
        mPc = tgt; mHeld = 0; kind = 1;
      end else if (!bus.stallF_i) begin
        word = mBuf; kind = 2; mPc = mPc + 4; mHeld = 0;
      end
    end else if (mDraining) begin
      if (bus.pcsrcE_i) mPend = tgt;
      if (bus.imem_ack_i) begin
        mPc = mPend; mDraining = 0;
      end
      kind = 1;
    end else if (bus.imem_ack_i) begin
      if (bus.pcsrcE_i) begin
        mPc = tgt; kind = 1;
      end else if (bus.stallF_i) begin
        mBuf = bus.imem_rdata_i; mHeld = 1; kind = 1;
      end else begin
        word = bus.imem_rdata_i; kind = 2; mPc = mPc + 4;
      end
    end else begin
      if (bus.pcsrcE_i) begin
        mPend = tgt; mDraining = 1;
      end
      kind = 1;
    end
    if (bus.flushD_i) kind = 1;
    else if (bus.stallD_i) kind = 0;
    if (kind == 1) begin
      mInstr = NOP; mPcD = 32'h0; mPc4D = 32'h0; mValid = 1'b0;
    end else if (kind == 2) begin
      mInstr = word; mPcD = atPc; mPc4D = atPc + 4; mValid = 1'b1;
    end
  endfunction

  task automatic set_in(input logic sF, input logic sD, input logic fD, input logic pcs,
                        input logic [31:0] tgt, input logic ack, input logic [31:0] rd);
    bus.stallF_i     = sF;
    bus.stallD_i     = sD;
    bus.flushD_i     = fD;
    bus.pcsrcE_i     = pcs;
    bus.pctargetE_i  = tgt;
    bus.imem_ack_i   = ack;
    bus.imem_rdata_i = rd;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFF);
    rst = 1'b1;
    #1;
    nCompared++; if (bus.imem_req_o !== 1'b0) begin nMismatched++; $display("FAIL reset_req: got %b want 0", bus.imem_req_o); end
    nCompared++; if (bus.instrD_o !== NOP) begin nMismatched++; $display("FAIL reset_instr: got %h want %h", bus.instrD_o, NOP); end
    nCompared++; if (bus.pcD_o !== 32'h0) begin nMismatched++; $display("FAIL reset_pcD: got %h want 0", bus.pcD_o); end
    nCompared++; if (bus.pcplus4D_o !== 32'h0) begin nMismatched++; $display("FAIL reset_pc4: got %h want 0", bus.pcplus4D_o); end
    nCompared++; if (bus.validD_o !== 1'b0) begin nMismatched++; $display("FAIL reset_valid: got %b want 0", bus.validD_o); end
    repeat (2) tick();
  endtask

  task automatic test_first_fetch();
    set_in(0, 0, 0, 0, 32'h0, 1, 32'h0050_0093);
    rst = 1'b0;
    #1;
    nCompared++; if (bus.imem_req_o !== 1'b0) begin nMismatched++; $display("FAIL idle_req: got %b want 0", bus.imem_req_o); end
    tick();
    nCompared++; if (bus.imem_req_o !== 1'b1) begin nMismatched++; $display("FAIL first_req: got %b want 1", bus.imem_req_o); end
    nCompared++; if (bus.imem_addr_o !== 32'h0) begin nMismatched++; $display("FAIL first_addr: got %h want 0", bus.imem_addr_o); end
    tick();
    nCompared++; if (bus.instrD_o !== 32'h0050_0093) begin nMismatched++; $display("FAIL first_instr: got %h want 00500093", bus.instrD_o); end
    nCompared++; if (bus.pcD_o !== 32'h0) begin nMismatched++; $display("FAIL first_pcD: got %h want 0", bus.pcD_o); end
    nCompared++; if (bus.pcplus4D_o !== 32'h4) begin nMismatched++; $display("FAIL first_pc4: got %h want 4", bus.pcplus4D_o); end
    nCompared++; if (bus.validD_o !== 1'b1) begin nMismatched++; $display("FAIL first_valid: got %b want 1", bus.validD_o); end
    nCompared++; if (bus.imem_addr_o !== 32'h4) begin nMismatched++; $display("FAIL first_next_addr: got %h want 4", bus.imem_addr_o); end
  endtask

  task automatic test_wait_states();
    set_in(0, 0, 0, 0, 32'h0, 1, 32'h1111_1111);
    tick();
    set_in(0, 0, 0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      nCompared++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h8) begin nMismatched++; $display("FAIL wait_addr[%0d]: got req=%b addr=%h want req=1 addr=8", i, bus.imem_req_o, bus.imem_addr_o); end
      nCompared++; if (bus.validD_o !== 1'b0) begin nMismatched++; $display("FAIL wait_bubble[%0d]: got %b want 0", i, bus.validD_o); end
    end
    set_in(0, 0, 0, 0, 32'h0, 1, 32'h2222_2222);
    tick();
    nCompared++; if (bus.validD_o !== 1'b1 || bus.pcD_o !== 32'h8) begin nMismatched++; $display("FAIL wait_done: got valid=%b pcD=%h want valid=1 pcD=8", bus.validD_o, bus.pcD_o); end
    nCompared++; if (bus.instrD_o !== 32'h2222_2222) begin nMismatched++; $display("FAIL wait_instr: got %h want 22222222", bus.instrD_o); end
  endtask

  task automatic test_hold();
    set_in(1, 1, 0, 0, 32'h0, 1, 32'hDEAD_BEEF);
    tick();
    nCompared++; if (bus.imem_req_o !== 1'b0) begin nMismatched++; $display("FAIL hold_req0: got %b want 0", bus.imem_req_o); end
    nCompared++; if (bus.pcD_o !== 32'h8 || bus.instrD_o !== 32'h2222_2222) begin nMismatched++; $display("FAIL hold_ifid0: got pcD=%h instr=%h want pcD=8 instr=22222222", bus.pcD_o, bus.instrD_o); end
    set_in(1, 1, 0, 0, 32'h0, 0, 32'h0);
    tick();
    nCompared++; if (bus.imem_req_o !== 1'b0) begin nMismatched++; $display("FAIL hold_req1: got %b want 0", bus.imem_req_o); end
    nCompared++; if (bus.pcD_o !== 32'h8 || bus.validD_o !== 1'b1) begin nMismatched++; $display("FAIL hold_ifid1: got pcD=%h valid=%b want pcD=8 valid=1", bus.pcD_o, bus.validD_o); end
    set_in(0, 0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    nCompared++; if (bus.instrD_o !== 32'hDEAD_BEEF) begin nMismatched++; $display("FAIL hold_instr: got %h want deadbeef", bus.instrD_o); end
    nCompared++; if (bus.pcD_o !== 32'hC || bus.pcplus4D_o !== 32'h10 || bus.validD_o !== 1'b1) begin nMismatched++; $display("FAIL hold_pcD: got pcD=%h pc4=%h valid=%b want c/10/1", bus.pcD_o, bus.pcplus4D_o, bus.validD_o); end
    nCompared++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h10) begin nMismatched++; $display("FAIL hold_next_addr: got req=%b addr=%h want 1/10", bus.imem_req_o, bus.imem_addr_o); end
  endtask

  task automatic test_redirect_drain();
    set_in(0, 0, 0, 0, 32'h0, 1, 32'h3333_3333);
    repeat (4) tick();
    nCompared++; if (bus.imem_addr_o !== 32'h20) begin nMismatched++; $display("FAIL drain_setup: got %h want 20", bus.imem_addr_o); end
    set_in(0, 0, 0, 1, 32'h100, 0, 32'h0);
    tick();
    nCompared++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h20) begin nMismatched++; $display("FAIL drain_addr0: got req=%b addr=%h want 1/20", bus.imem_req_o, bus.imem_addr_o); end
    nCompared++; if (bus.validD_o !== 1'b0) begin nMismatched++; $display("FAIL drain_bubble0: got %b want 0", bus.validD_o); end
    set_in(0, 0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    nCompared++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h20) begin nMismatched++; $display("FAIL drain_addr1: got req=%b addr=%h want 1/20", bus.imem_req_o, bus.imem_addr_o); end
    set_in(0, 0, 0, 0, 32'h0, 1, 32'hBAD0_0020);
    tick();
    nCompared++; if (bus.validD_o !== 1'b0) begin nMismatched++; $display("FAIL drain_dropped: got valid=%b pcD=%h want valid=0", bus.validD_o, bus.pcD_o); end
    nCompared++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100) begin nMismatched++; $display("FAIL drain_target: got req=%b addr=%h want 1/100", bus.imem_req_o, bus.imem_addr_o); end
    set_in(0, 0, 0, 0, 32'h0, 1, 32'h4444_4444);
    tick();
    nCompared++; if (bus.pcD_o !== 32'h100 || bus.instrD_o !== 32'h4444_4444 || bus.validD_o !== 1'b1) begin nMismatched++; $display("FAIL drain_resume: got pcD=%h instr=%h valid=%b want 100/44444444/1", bus.pcD_o, bus.instrD_o, bus.validD_o); end
  endtask

  task automatic test_flush_stall();
    set_in(0, 1, 1, 0, 32'h0, 1, 32'h7777_7777);
    tick();
    nCompared++; if (bus.instrD_o !== NOP || bus.validD_o !== 1'b0) begin nMismatched++; $display("FAIL flush_over_stall: got instr=%h valid=%b want 00000013/0", bus.instrD_o, bus.validD_o); end
    nCompared++; if (bus.pcD_o !== 32'h0 || bus.pcplus4D_o !== 32'h0) begin nMismatched++; $display("FAIL flush_pcs: got pcD=%h pc4=%h want 0/0", bus.pcD_o, bus.pcplus4D_o); end
  endtask

  task automatic test_wrap_and_reset();
    set_in(0, 0, 0, 1, 32'hFFFF_FFFF, 1, 32'h0);
    tick();
    nCompared++; if (bus.imem_addr_o !== 32'hFFFF_FFFC) begin nMismatched++; $display("FAIL wrap_target_align: got %h want fffffffc", bus.imem_addr_o); end
    set_in(0, 0, 0, 0, 32'h0, 1, 32'h5555_5555);
    tick();
    nCompared++; if (bus.pcD_o !== 32'hFFFF_FFFC || bus.pcplus4D_o !== 32'h0 || bus.validD_o !== 1'b1) begin nMismatched++; $display("FAIL wrap_pc4: got pcD=%h pc4=%h valid=%b want fffffffc/0/1", bus.pcD_o, bus.pcplus4D_o, bus.validD_o); end
    nCompared++; if (bus.imem_addr_o !== 32'h0) begin nMismatched++; $display("FAIL wrap_next_addr: got %h want 0", bus.imem_addr_o); end
    set_in(0, 0, 0, 1, 32'h40, 0, 32'h0);
    tick();
    set_in(0, 0, 0, 0, 32'h0, 1, 32'h9999_9999);
    rst = 1'b1;
    #1;
    nCompared++; if (bus.imem_req_o !== 1'b0) begin nMismatched++; $display("FAIL drain_reset_req: got %b want 0", bus.imem_req_o); end
    tick();
    rst = 1'b0;
    tick();
    nCompared++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin nMismatched++; $display("FAIL restart_addr: got req=%b addr=%h want 1/0", bus.imem_req_o, bus.imem_addr_o); end
    set_in(0, 0, 0, 0, 32'h0, 1, 32'h6666_6666);
    tick();
    nCompared++; if (bus.pcD_o !== 32'h0 || bus.instrD_o !== 32'h6666_6666 || bus.validD_o !== 1'b1) begin nMismatched++; $display("FAIL restart_fetch: got pcD=%h instr=%h valid=%b want 0/66666666/1", bus.pcD_o, bus.instrD_o, bus.validD_o); end
  endtask

  task automatic test_random();
    logic sF;
    logic expReq;
    set_in(0, 0, 0, 0, 32'h0, 0, 32'h0);
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      expReq = mStarted && !mHeld;
      nCompared++; if (bus.imem_req_o !== expReq) begin nMismatched++; $display("FAIL rnd_req@%0d: got %b want %b", cyc, bus.imem_req_o, expReq); end
      if (expReq) begin
        nCompared++; if (bus.imem_addr_o !== mPc) begin nMismatched++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, bus.imem_addr_o, mPc); end
      end
      nCompared++; if (bus.instrD_o !== mInstr) begin nMismatched++; $display("FAIL rnd_instr@%0d: got %h want %h", cyc, bus.instrD_o, mInstr); end
      nCompared++; if (bus.pcD_o !== mPcD) begin nMismatched++; $display("FAIL rnd_pcD@%0d: got %h want %h", cyc, bus.pcD_o, mPcD); end
      nCompared++; if (bus.pcplus4D_o !== mPc4D) begin nMismatched++; $display("FAIL rnd_pc4@%0d: got %h want %h", cyc, bus.pcplus4D_o, mPc4D); end
      nCompared++; if (bus.validD_o !== mValid) begin nMismatched++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, bus.validD_o, mValid); end
      sF = ($urandom_range(0, 99) < 20);
      set_in(sF,
             sF ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 99) < 5),
             ($urandom_range(0, 99) < 8),
             $urandom(),
             ($urandom_range(0, 99) < 60),
             {bus.imem_addr_o[15:0] ^ 16'hA5C3, bus.imem_addr_o[31:16]} ^ $urandom_range(0, 255));
      model_step();
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_first_fetch();
    test_wait_states();
    test_hold();
    test_redirect_drain();
    test_flush_stall();
    test_wrap_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
